// File: rtl/dp_ram_ctrl.sv
// Dual-port RAM front end: port A serves instruction fetch, port B is arbitrated between LSU and
// debug. Optional macro DP_RAM_CTRL_RR_EN selects round-robin instead of fixed data>dbg priority.
module dp_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,

    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,

    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [3:0]            dbg_be_i,
    input  logic [31:0]           dbg_addr_i,
    input  logic [31:0]           dbg_wdata_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [31:0]           dbg_rdata_o,

    output logic                  ram_en_a_o,
    output logic                  ram_we_a_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_a_o,
    output logic [31:0]           ram_wdata_a_o,
    output logic [3:0]            ram_be_a_o,
    input  logic [31:0]           ram_rdata_a_i,

    output logic                  ram_en_b_o,
    output logic                  ram_we_b_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_b_o,
    output logic [31:0]           ram_wdata_b_o,
    output logic [3:0]            ram_be_b_o,
    input  logic [31:0]           ram_rdata_b_i,

    output logic                  init_done_o
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  init_done_q;
    logic                  instr_rvalid_q;
    logic                  data_rvalid_q;
    logic                  dbg_rvalid_q;

    logic run;
    logic instr_gnt;
    logic data_gnt;
    logic dbg_gnt;

    // Grants are suppressed in the reset cycle so nothing is accepted while state is reloaded.
    assign run       = (state_q == StRun) && !rst_i;
    assign instr_gnt = run && instr_req_i;

`ifdef DP_RAM_CTRL_RR_EN
    logic rr_dbg_q;  // 1: dbg wins the next contended cycle
    logic contended;
    assign contended = run && data_req_i && dbg_req_i;
`endif

    always_comb begin
        data_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (run) begin
            if (data_req_i && dbg_req_i) begin
`ifdef DP_RAM_CTRL_RR_EN
                dbg_gnt  = rr_dbg_q;
                data_gnt = !rr_dbg_q;
`else
                data_gnt = 1'b1;
`endif
            end else begin
                data_gnt = data_req_i;
                dbg_gnt  = dbg_req_i;
            end
        end
    end

    always_comb begin
        ram_en_a_o    = 1'b0;
        ram_we_a_o    = 1'b0;
        ram_be_a_o    = 4'hF;
        ram_wdata_a_o = 32'h0;
        ram_addr_a_o  = instr_addr_i[ADDR_WIDTH+1:2];
        if (!rst_i && state_q == StClear) begin
            ram_en_a_o   = 1'b1;
            ram_we_a_o   = 1'b1;
            ram_addr_a_o = cnt_q;
        end else begin
            ram_en_a_o = instr_gnt;
        end
    end

    always_comb begin
        ram_en_b_o    = data_gnt || dbg_gnt;
        ram_we_b_o    = data_gnt && data_we_i;
        ram_be_b_o    = data_be_i;
        ram_wdata_b_o = data_wdata_i;
        ram_addr_b_o  = data_addr_i[ADDR_WIDTH+1:2];
        if (dbg_gnt) begin
            ram_we_b_o    = dbg_we_i;
            ram_be_b_o    = dbg_be_i;
            ram_wdata_b_o = dbg_wdata_i;
            ram_addr_b_o  = dbg_addr_i[ADDR_WIDTH+1:2];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= CLEAR_ON_RESET ? StClear : StRun;
            cnt_q          <= '0;
            init_done_q    <= 1'b0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            dbg_rvalid_q   <= 1'b0;
        end else begin
            instr_rvalid_q <= instr_gnt;
            data_rvalid_q  <= data_gnt;
            dbg_rvalid_q   <= dbg_gnt;
            unique case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end
                end
                StRun: begin
                    init_done_q <= 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef DP_RAM_CTRL_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_dbg_q <= 1'b0;
        end else if (contended) begin
            rr_dbg_q <= data_gnt;
        end
    end
`endif

    assign instr_gnt_o    = instr_gnt;
    assign data_gnt_o     = data_gnt;
    assign dbg_gnt_o      = dbg_gnt;
    assign instr_rvalid_o = instr_rvalid_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign dbg_rvalid_o   = dbg_rvalid_q;
    assign instr_rdata_o  = ram_rdata_a_i;
    assign data_rdata_o   = ram_rdata_b_i;
    assign dbg_rdata_o    = ram_rdata_b_i;
    assign init_done_o    = init_done_q;

    // Byte-offset and above-range address bits are intentionally dropped (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0],
                                data_addr_i[31:ADDR_WIDTH+2], data_addr_i[1:0],
                                dbg_addr_i[31:ADDR_WIDTH+2], dbg_addr_i[1:0]};

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Self-checking bench for dp_ram_ctrl (ADDR_WIDTH=4) with a behavioural dual-port RAM and a
// response scoreboard; expectations follow DP_RAM_CTRL_RR_EN when it is defined.
module tb_dp_ram_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_req, i_gnt, i_rv;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_we, d_gnt, d_rv;
    logic [3:0]    d_be;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          g_req, g_we, g_gnt, g_rv;
    logic [3:0]    g_be;
    logic [31:0]   g_addr, g_wdata, g_rdata;
    logic          en_a, we_a, en_b, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [31:0]   wdata_a, wdata_b, rdata_a, rdata_b;
    logic [3:0]    be_a, be_b;
    logic          init_done;

    dp_ram_ctrl #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(i_req), .instr_addr_i(i_addr), .instr_gnt_o(i_gnt),
        .instr_rvalid_o(i_rv), .instr_rdata_o(i_rdata),
        .data_req_i(d_req), .data_we_i(d_we), .data_be_i(d_be), .data_addr_i(d_addr),
        .data_wdata_i(d_wdata), .data_gnt_o(d_gnt), .data_rvalid_o(d_rv), .data_rdata_o(d_rdata),
        .dbg_req_i(g_req), .dbg_we_i(g_we), .dbg_be_i(g_be), .dbg_addr_i(g_addr),
        .dbg_wdata_i(g_wdata), .dbg_gnt_o(g_gnt), .dbg_rvalid_o(g_rv), .dbg_rdata_o(g_rdata),
        .ram_en_a_o(en_a), .ram_we_a_o(we_a), .ram_addr_a_o(addr_a), .ram_wdata_a_o(wdata_a),
        .ram_be_a_o(be_a), .ram_rdata_a_i(rdata_a),
        .ram_en_b_o(en_b), .ram_we_b_o(we_b), .ram_addr_b_o(addr_b), .ram_wdata_b_o(wdata_b),
        .ram_be_b_o(be_b), .ram_rdata_b_i(rdata_b),
        .init_done_o(init_done)
    );

    // Behavioural RAM: 1-cycle read latency, read-before-write on each port.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (en_a) begin
            if (we_a) begin
                for (int b = 0; b < 4; b++) if (be_a[b]) mem[addr_a][8*b +: 8] <= wdata_a[8*b +: 8];
            end else begin
                rdata_a <= mem[addr_a];
            end
        end
        if (en_b) begin
            if (we_b) begin
                for (int b = 0; b < 4; b++) if (be_b[b]) mem[addr_b][8*b +: 8] <= wdata_b[8*b +: 8];
            end else begin
                rdata_b <= mem[addr_b];
            end
        end
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req, d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr, d_wdata;
        logic        g_req, g_we;
        logic [3:0]  g_be;
        logic [31:0] g_addr, g_wdata;
        logic        e_i, e_d, e_g;
    } vec_t;

    typedef struct {
        int          port;  // 0 instr, 1 data, 2 dbg
        logic        rd;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [3:0] db,
                                input logic [31:0] da, input logic [31:0] dd,
                                input logic gr, input logic gw, input logic [3:0] gb,
                                input logic [31:0] ga, input logic [31:0] gd,
                                input logic ei, input logic ed, input logic eg);
        vec_t v;
        v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_be = db; v.d_addr = da; v.d_wdata = dd;
        v.g_req = gr; v.g_we = gw; v.g_be = gb; v.g_addr = ga; v.g_wdata = gd;
        v.e_i = ei; v.e_d = ed; v.e_g = eg;
        return v;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[widx(a)][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic idle();
        i_req = 0; i_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        g_req = 0; g_we = 0; g_be = 0; g_addr = 0; g_wdata = 0;
    endtask

    // Compare rvalid/rdata against responses queued in the previous cycle.
    task automatic check_resp(input string nm);
        logic        ev [3];
        logic        rd [3];
        logic [31:0] ed [3];
        for (int p = 0; p < 3; p++) begin ev[p] = 0; rd[p] = 0; ed[p] = 0; end
        while (sb.size() > 0) begin
            resp_t r = sb.pop_front();
            ev[r.port] = 1; rd[r.port] = r.rd; ed[r.port] = r.data;
        end
        chk({nm, ".instr_rvalid"}, {31'b0, i_rv}, {31'b0, ev[0]});
        chk({nm, ".data_rvalid"},  {31'b0, d_rv}, {31'b0, ev[1]});
        chk({nm, ".dbg_rvalid"},   {31'b0, g_rv}, {31'b0, ev[2]});
        if (rd[0]) chk({nm, ".instr_rdata"}, i_rdata, ed[0]);
        if (rd[1]) chk({nm, ".data_rdata"},  d_rdata, ed[1]);
        if (rd[2]) chk({nm, ".dbg_rdata"},   g_rdata, ed[2]);
    endtask

    task automatic apply(input vec_t v, input string nm);
        resp_t r;
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_be = v.d_be; d_addr = v.d_addr; d_wdata = v.d_wdata;
        g_req = v.g_req; g_we = v.g_we; g_be = v.g_be; g_addr = v.g_addr; g_wdata = v.g_wdata;
        @(negedge clk);
        chk({nm, ".instr_gnt"}, {31'b0, i_gnt}, {31'b0, v.e_i});
        chk({nm, ".data_gnt"},  {31'b0, d_gnt}, {31'b0, v.e_d});
        chk({nm, ".dbg_gnt"},   {31'b0, g_gnt}, {31'b0, v.e_g});
        // Reads see the pre-write contents of this cycle.
        if (v.e_i) begin r.port = 0; r.rd = 1; r.data = ref_mem[widx(v.i_addr)]; sb.push_back(r); end
        if (v.e_d) begin r.port = 1; r.rd = !v.d_we; r.data = ref_mem[widx(v.d_addr)]; sb.push_back(r); end
        if (v.e_g) begin r.port = 2; r.rd = !v.g_we; r.data = ref_mem[widx(v.g_addr)]; sb.push_back(r); end
        if (v.e_d && v.d_we) ref_write(v.d_addr, v.d_be, v.d_wdata);
        if (v.e_g && v.g_we) ref_write(v.g_addr, v.g_be, v.g_wdata);
        @(posedge clk); #1;
        check_resp(nm);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        sb.delete();
    endtask

    // Run n clear cycles with every requester asserted; port A must carry the zero-fill.
    task automatic clear_cycles(input int n, input string nm);
        i_req = 1; i_addr = 32'h4; d_req = 1; d_addr = 32'h8; g_req = 1; g_addr = 32'hC;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({nm, ".en_a"},      {31'b0, en_a}, 32'd1);
            chk({nm, ".we_a"},      {31'b0, we_a}, 32'd1);
            chk({nm, ".be_a"},      {28'b0, be_a}, 32'hF);
            chk({nm, ".wdata_a"},   wdata_a, 32'h0);
            chk({nm, ".addr_a"},    {28'b0, addr_a}, k);
            chk({nm, ".gnts"},      {29'b0, i_gnt, d_gnt, g_gnt}, 32'd0);
            chk({nm, ".init_done"}, {31'b0, init_done}, 32'd0);
            @(posedge clk); #1;
        end
        idle();
    endtask

    vec_t tbl [11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit   exp_dbg;

        // Port A collisions read old data; port B RAW next cycle sees new data; 0x40 aliases 0x00.
        tbl[0]  = mk(0, 0,     1, 1, 4'b0011, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0,      0, 1, 0);
        tbl[1]  = mk(0, 0,     1, 0, 4'hF,    32'h10, 0,            0, 0, 0, 0, 0,      0, 1, 0);
        tbl[2]  = mk(1, 32'h10, 0, 0, 0, 0, 0,     1, 1, 4'hF, 32'h10, 32'h12345678,  1, 0, 1);
        tbl[3]  = mk(1, 32'h10, 0, 0, 0, 0, 0,     0, 0, 0, 0, 0,                     1, 0, 0);
        tbl[4]  = mk(0, 0,     0, 0, 0, 0, 0,      1, 1, 4'hF, 32'h40, 32'hA5A5A5A5,  0, 0, 1);
        tbl[5]  = mk(0, 0,     1, 0, 4'hF, 32'h00, 0, 0, 0, 0, 0, 0,                  0, 1, 0);
        tbl[6]  = mk(1, 32'h04, 0, 0, 0, 0, 0,     1, 0, 4'hF, 32'h13, 0,             1, 0, 1);
        tbl[7]  = mk(1, 32'h08, 1, 1, 4'b1100, 32'h08, 32'h11223344, 0, 0, 0, 0, 0,  1, 1, 0);
        tbl[8]  = mk(0, 0,     1, 0, 4'hF, 32'h08, 0, 1, 0, 4'hF, 32'h04, 0,          0, 1, 0);
        tbl[9]  = mk(0, 0,     0, 0, 0, 0, 0,      1, 0, 4'hF, 32'h04, 0,             0, 0, 1);
        tbl[10] = mk(0, 0,     0, 0, 0, 0, 0,      0, 0, 0, 0, 0,                     0, 0, 0);

        do_reset();
        clear_cycles(7, "clr_part");
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        clear_cycles(DEPTH, "clr_full");
        @(negedge clk);
        chk("init_done_rise", {31'b0, init_done}, 32'd1);
        @(posedge clk); #1;
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;

        for (int t = 0; t < 11; t++) apply(tbl[t], $sformatf("vec%0d", t));

        // Fresh reset: RR pointer back to data, RAM re-zeroed (word 0 held 0xA5A5A5A5).
        do_reset();
        clear_cycles(DEPTH, "clr_again");
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;
        for (int k = 0; k < 4; k++) begin
`ifdef DP_RAM_CTRL_RR_EN
            exp_dbg = (k % 2) == 1;
`else
            exp_dbg = 1'b0;
`endif
            v = mk(0, 0, 1, 0, 4'hF, 32'h40, 0, 1, 0, 4'hF, 32'h04, 0, 0, !exp_dbg, exp_dbg);
            apply(v, $sformatf("contend%0d", k));
        end
        apply(tbl[10], "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_ram_ctrl.md
Name: dp_ram_ctrl

Overview:
Front-end controller for the core's dual-port 32-bit RAM. Port A is dedicated to instruction fetch. Port B is shared, with arbitration, between the LSU data port and the debug/boot-loader port. After reset, a clear FSM writes every word to zero before any requester is granted. All requester interfaces use the req/gnt/rvalid protocol; RAM read latency is one cycle.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; RAM depth = 2**ADDR_WIDTH words.
CLEAR_ON_RESET, 1, 1 = zero-fill RAM after reset; 0 = go directly to RUN.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
instr_req_i/instr_gnt_o/instr_rvalid_o  in/out/out  1  fetch handshake
instr_addr_i  in  32  fetch byte address
instr_rdata_o  out  32  fetch data, valid with instr_rvalid_o
data_req_i/data_we_i  in  1  LSU request / write enable
data_be_i  in  4  LSU byte enables
data_addr_i/data_wdata_i  in  32  LSU byte address / write data
data_gnt_o/data_rvalid_o  out  1  LSU grant / response
data_rdata_o  out  32  LSU read data
dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o  (same widths and meanings as data_*, debug port)
ram_en_a_o, ram_we_a_o  out  1;  ram_addr_a_o  out  ADDR_WIDTH;  ram_wdata_a_o  out  32;  ram_be_a_o  out  4;  ram_rdata_a_i  in  32
ram_en_b_o, ram_we_b_o, ram_addr_b_o, ram_wdata_b_o, ram_be_b_o, ram_rdata_b_i  (same widths as port A)
init_done_o  out  1  high once FSM is in RUN

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high. The reset condition is sampled on the clk_i rising edge.
- Reset values: all gnt/rvalid outputs 0, init_done_o 0, ram_en_*/ram_we_* 0, clear counter 0, RR pointer = data. FSM -> CLEAR if CLEAR_ON_RESET else RUN.
- FSM states:
  - CLEAR: each cycle drive port A with en=1, we=1, be=4'hF, wdata=0, addr=cnt; cnt++. After the write of word 2**ADDR_WIDTH-1, go to RUN. Takes exactly 2**ADDR_WIDTH cycles. All gnt outputs are 0 in CLEAR.
  - RUN: normal operation. init_done_o=1. There is no exit except reset.
- Reset asserted mid-CLEAR restarts CLEAR from word 0.
- Word address = addr[ADDR_WIDTH+1:2]. Upper bits and addr[1:0] are ignored, so out-of-range addresses alias/wrap.
- Port A (RUN): instr_gnt_o = instr_req_i, combinational, no stall. ram_en_a_o = instr_req_i, ram_we_a_o = 0. instr_rvalid_o is high exactly one cycle after the grant. instr_rdata_o = ram_rdata_a_i.
- Port B (RUN):
  - At most one grant per cycle, combinational gnt in the same cycle as req. Address, we, be and wdata of the winner are forwarded to RAM port B with ram_en_b_o = 1.
  - Requester signals must stay stable while req is high and gnt is low.
  - Winner ID is registered. The winner's rvalid pulses the next cycle (reads and writes both get rvalid). Both data_rdata_o and dbg_rdata_o are driven from ram_rdata_b_i; each is meaningful only while its own rvalid is high.
  - Back-to-back grants every cycle are allowed (throughput 1/cycle).
- Arbitration: with a single requester, it is granted. On contention, the policy is set by the optional feature below.
- Same-word collisions:
  - Port A read and port B write in the same cycle: port A returns old data.
  - Port B read-after-write on the next cycle returns new data.
- No outstanding-request limit beyond 1. rvalid always follows the grant by exactly 1 cycle.

Optional Feature:
DP_RAM_CTRL_RR_EN
- Defined: on data/dbg contention, round-robin. Grant the requester not granted in the last contended cycle; the pointer updates only on contended grants.
- Undefined: fixed priority, data > dbg. dbg may starve indefinitely.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset -> 16 port-A writes of 0 to addr 0..15, init_done_o rises on cycle 17, any req before that sees gnt=0.
2. Reset at clear count 7 -> counter returns to 0, 16 full clear cycles follow, init_done_o stays 0 until done.
3. RUN: data write addr 0x10, wdata 0xDEADBEEF, be 4'b0011; next cycle data read 0x10 -> data_rvalid_o, data_rdata_o=0x0000BEEF.
4. data and dbg req every cycle for 4 cycles: with RR_EN, grants alternate data, dbg, data, dbg; without it, data is granted 4 times and dbg_gnt_o stays 0.
5. instr read 0x10 concurrent with dbg write 0x10 = 0x12345678 -> instr_rdata_o = old value; following instr read -> 0x12345678.
6. Address aliasing, ADDR_WIDTH=4: write 0x40 = 0xA5A5A5A5, read 0x00 -> 0xA5A5A5A5.
